// File: rtl/seq_ram_loader.sv
// Streams valid/ready pattern words into consecutive sequence-RAM write locations.
// Optional SEQ_LOADER_CHECKSUM_EN: the s_last beat carries an XOR checksum instead of data.
module seq_ram_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              CLK_50,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   max_len,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] wraddress_sig,
  output logic [DATA_W-1:0] data_sig,
  output logic              wren_sig,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   max_q, max_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              accept, wr, at_limit;
`ifdef SEQ_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  assign s_ready       = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign err           = err_q;
  assign word_count    = wcnt_q;
  assign wren_sig      = wren_q;
  assign wraddress_sig = waddr_q;
  assign data_sig      = wdata_q;
  assign accept        = s_valid && s_ready;
  assign at_limit      = (wcnt_q + 1'b1) == max_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    max_d   = max_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    wren_d  = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wr      = 1'b0;
`ifdef SEQ_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        base_d  = base_addr;
        max_d   = (max_len == '0 || max_len > DEPTH_C) ? DEPTH_C : max_len;
        wcnt_d  = '0;
        err_d   = 1'b0;
`ifdef SEQ_LOADER_CHECKSUM_EN
        csum_d  = '0;
`endif
        state_d = S_LOAD;
      end
      S_LOAD: if (accept) begin
`ifdef SEQ_LOADER_CHECKSUM_EN
        if (s_last) begin
          if (s_data != csum_q) err_d = 1'b1;
          state_d = S_DONE;
        end else begin
          wr = 1'b1;
          if (at_limit) begin
            err_d   = 1'b1;
            state_d = S_DRAIN;
          end
        end
`else
        wr = 1'b1;
        if (s_last) state_d = S_DONE;
        else if (at_limit) begin
          err_d   = 1'b1;
          state_d = S_DRAIN;
        end
`endif
      end
      S_DRAIN: if (accept && s_last) begin
`ifdef SEQ_LOADER_CHECKSUM_EN
        if (s_data != csum_q) err_d = 1'b1;
`endif
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    // Write address wraps naturally within ADDR_W bits.
    if (wr) begin
      wren_d  = 1'b1;
      waddr_d = base_q + wcnt_q[ADDR_W-1:0];
      wdata_d = s_data;
      wcnt_d  = wcnt_q + 1'b1;
`ifdef SEQ_LOADER_CHECKSUM_EN
      csum_d  = csum_q ^ s_data;
`endif
    end
  end

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      max_q   <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      wren_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef SEQ_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      max_q   <= max_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      wren_q  <= wren_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef SEQ_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_ram_loader.sv
// Directed bench for seq_ram_loader; checksum cases run when SEQ_LOADER_CHECKSUM_EN is defined.
module tb_seq_ram_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  base_addr;
  logic [7:0]  max_len;
  logic [31:0] s_data;
  logic        s_valid, s_last, s_ready;
  logic [6:0]  waddr;
  logic [31:0] wdata;
  logic        wren, busy, done, err;
  logic [7:0]  wcnt;
  int n_chk = 0;
  int n_err = 0;

  seq_ram_loader dut (
    .CLK_50(clk), .reset(rst), .start(start), .base_addr(base_addr), .max_len(max_len),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .wraddress_sig(waddr), .data_sig(wdata), .wren_sig(wren), .busy(busy),
    .done(done), .err(err), .word_count(wcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [6:0] b, input logic [7:0] l);
    start = 1'b1; base_addr = b; max_len = l;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_ready", s_ready, 1);
    chk("start_wcnt", wcnt, 0);
    chk("start_err", err, 0);
  endtask

  // n beats, last on the n-th; gap idle cycles between beats, optionally pulsing start.
  task automatic run_load(input logic [6:0] b, input logic [7:0] l, input int n,
                          input logic [31:0] d0, input int gap, input bit poke);
    int lim;
    lim = (l == 0 || l > 128) ? 128 : int'(l);
    do_start(b, l);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1; s_data = d0 + i; s_last = (i == n - 1);
      tick();
      s_valid = 1'b0; s_last = 1'b0;
      chk("beat_wren", wren, (i < lim) ? 1 : 0);
      if (i < lim) begin
        chk("beat_addr", waddr, 32'(7'(b + 7'(i))));
        chk("beat_data", wdata, d0 + i);
      end
      chk("beat_wcnt", wcnt, (i + 1 < lim) ? i + 1 : lim);
      chk("beat_done", done, (i == n - 1) ? 1 : 0);
      chk("beat_ready", s_ready, (i == n - 1) ? 0 : 1);
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          start = poke; base_addr = 7'h55; max_len = 8'd1;
          tick();
          start = 1'b0;
          chk("gap_wren", wren, 0);
          chk("gap_wcnt", wcnt, (i + 1 < lim) ? i + 1 : lim);
          chk("gap_busy", busy, 1);
        end
      end
    end
    tick();
    chk("end_busy", busy, 0);
    chk("end_done", done, 0);
    chk("end_wren", wren, 0);
    chk("end_err", err, (n > lim) ? 1 : 0);
    chk("end_wcnt", wcnt, (n < lim) ? n : lim);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; max_len = '0;
    s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    #1;
    chk("rst_ready", s_ready, 0);
    chk("rst_wren", wren, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", waddr, 0);
    chk("rst_data", wdata, 0);
    chk("rst_wcnt", wcnt, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

`ifdef SEQ_LOADER_CHECKSUM_EN
    do_start(7'h00, 8'd8);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = (i == 2) ? 32'h3 : 32'(i + 1); s_last = (i == 2);
      tick();
      chk("cs_wren", wren, (i < 2) ? 1 : 0);
      if (i < 2) chk("cs_data", wdata, 32'(i + 1));
      chk("cs_done", done, (i == 2) ? 1 : 0);
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk("cs_wcnt", wcnt, 2);
    chk("cs_err_ok", err, 0);
    tick();
    do_start(7'h00, 8'd8);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = (i == 2) ? 32'h7 : 32'(i + 1); s_last = (i == 2);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk("cs_bad_done", done, 1);
    chk("cs_bad_wcnt", wcnt, 2);
    chk("cs_bad_err", err, 1);
    tick();
`else
    // basic load
    run_load(7'h10, 8'd4, 4, 32'hA0, 0, 1'b0);
    // wrap with max_len 0 meaning full depth
    run_load(7'h7E, 8'd0, 4, 32'hB0, 0, 1'b0);
    // overflow: 2 written, 3 drained
    run_load(7'h20, 8'd2, 5, 32'hC0, 0, 1'b0);
    // throttled with ignored start, max_len above depth clamps
    run_load(7'h30, 8'd200, 3, 32'hD0, 2, 1'b1);

    // start in the DONE cycle is ignored
    do_start(7'h40, 8'd4);
    s_valid = 1'b1; s_data = 32'hE0; s_last = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    chk("dn_done", done, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("dn_ignored", busy, 0);
    chk("dn_wcnt", wcnt, 1);

    // reset mid-load after two words
    do_start(7'h50, 8'd4);
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = 32'hF0 + i; s_last = 1'b0;
      tick();
    end
    chk("mr_wcnt2", wcnt, 2);
    s_data = 32'hF2;
    rst = 1'b1;
    #1;
    chk("mr_ready", s_ready, 0);
    chk("mr_busy", busy, 0);
    chk("mr_wren", wren, 0);
    chk("mr_addr", waddr, 0);
    chk("mr_data", wdata, 0);
    chk("mr_wcnt", wcnt, 0);
    tick();
    chk("mr_nowrite", wren, 0);
    s_valid = 1'b0;
    rst = 1'b0;
    tick();
    run_load(7'h60, 8'd4, 4, 32'h11, 0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/seq_ram_loader.md
# seq_ram_loader

Write-side companion to the sequence player: accepts a stream of 32-bit pattern words on `CLK_50` through a valid/ready handshake and writes them into consecutive locations of the two-port sequence RAM through its write port (`wraddress_sig`/`data_sig`/`wren_sig`). The RAM read side, clocked by `slow_clk`, is consumed by the sequence state machine. The block bounds each load by a caller-supplied maximum length, wraps addresses within the RAM, and reports completion, word count and error status.

## Interface
- `DATA_W`, 32, RAM word width
- `ADDR_W`, 7, RAM address width
- `DEPTH`, 128, RAM words (2**ADDR_W)

- `CLK_50`  in  1  system clock; RAM write clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  single-cycle load request; honoured only in IDLE
- `base_addr`  in  ADDR_W  first RAM address; sampled on accepted `start`
- `max_len`  in  ADDR_W+1  maximum words to write; sampled on `start`; 0 or >DEPTH treated as DEPTH
- `s_data`  in  DATA_W  stream word
- `s_valid`  in  1  stream word valid
- `s_last`  in  1  final beat of the load
- `s_ready`  out  1  block accepts a beat this cycle
- `wraddress_sig`  out  ADDR_W  RAM write address
- `data_sig`  out  DATA_W  RAM write data
- `wren_sig`  out  1  RAM write strobe
- `busy`  out  1  high outside IDLE
- `done`  out  1  one-cycle pulse at end of load
- `err`  out  1  sticky error; cleared by accepted `start`
- `word_count`  out  ADDR_W+1  words written in current or last load

## Operation
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE: `s_ready` = 0. On `start`: latch `base_addr` and clamped `max_len`; clear `word_count` and `err`; go to LOAD.
- LOAD: `s_ready` = 1. A beat is accepted when `s_valid && s_ready`.
  - Each accepted data beat writes `s_data` to `(base + word_count) mod DEPTH`, then increments `word_count`.
  - On an accepted beat with `s_last` = 1, go to DONE.
  - On an accepted beat without `s_last` that brings `word_count` to `max_len`, set `err` and go to DRAIN.
- DRAIN: `s_ready` = 1. Accepted beats are discarded with no write. On an accepted beat with `s_last`, go to DONE.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE. `word_count` and `err` hold until the next `start`.
- `start` outside IDLE is ignored.
- Address arithmetic is ADDR_W bits with natural wrap: base 126 with 4 words writes 126, 127, 0, 1.

## Timing
- Reset values: `s_ready`, `wren_sig`, `busy`, `done`, `err` = 0; `wraddress_sig`, `data_sig`, `word_count` = 0; state IDLE.
- `start` to `s_ready` high: 1 cycle.
- Write latency: an accepted beat in cycle N produces registered `wren_sig`/`wraddress_sig`/`data_sig` in cycle N+1. `wren_sig` is high for one cycle per written word.
- Final beat in cycle N: DONE in N+1. `done` coincides with the final write strobe, and `s_ready` is 0 in N+1.
- Back-to-back beats sustain one word per cycle. `s_valid` gaps insert no writes.
- `word_count` updates in the same cycle as the corresponding `wren_sig`.
- Reset mid-load: all outputs clear immediately (asynchronous). No further write occurs; partially written RAM contents are left as is.
- `start` asserted in the DONE cycle is ignored; it is accepted from the following cycle.

## Configuration
- `SEQ_LOADER_CHECKSUM_EN` defined: the `s_last` beat carries a checksum and is not written to RAM.
  - Checksum = XOR of all words written in this load; 0 if none were written.
  - A mismatch sets `err`.
  - The checksum beat is compared in both LOAD and DRAIN. In DRAIN the compared value covers only the words actually written.
  - `word_count` excludes the checksum beat.
- Not defined: the `s_last` beat is an ordinary data word and is written.

## Test plan
- Basic load, macro off: start, base 0x10, max_len 4; words 0xA0..0xA3 back-to-back, last on 0xA3 -> writes at 0x10..0x13 in consecutive cycles; `done` with 4th strobe; `word_count` = 4; `err` = 0.
- Wrap: base 0x7E, 4 words -> addresses 0x7E, 0x7F, 0x00, 0x01.
- Overflow: max_len 2, 5 words, last on 5th -> 2 writes only; `err` = 1; beats 3-5 accepted with no strobe; `done` after 5th beat; `word_count` = 2.
- Throttled source plus ignored start: `s_valid` high every 3rd cycle, `start` pulsed during LOAD -> one strobe per beat, no restart, `word_count` unaffected.
- Reset mid-load after 2 of 4 words -> all outputs 0 immediately, state IDLE, no 3rd write; a subsequent start loads normally.
- Macro on: words 0x1, 0x2, then checksum 0x3 with last -> 2 writes, `err` = 0. Repeat with checksum 0x7 -> `err` = 1.
